alu_result_sender: RTL

Downstream stage of the ALU/compare unit. Captures each 16-bit registered result qualified by the ALU valid flag and ships it to the UART transmitter as two bytes, low byte first, using the transmitter's valid/busy handshake. A one-entry pending buffer absorbs a result that arrives mid-transfer. Results arriving while both the holding register and the pending buffer are occupied are dropped and flagged.

---
 rtl/alu_result_sender.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/alu_result_sender.sv
// rtl/alu_result_sender.sv - ships 16-bit ALU results to the UART transmitter as two bytes, low first
//
// Purpose: capture each ALU result qualified by OUT_Valid and hand it to the
// UART transmitter one byte at a time, low byte first, using the
// transmitter's TX_D_VLD / TX_Busy handshake. A one-entry pending buffer
// absorbs a result that arrives mid-transfer; a result that finds both the
// holding register and the pending buffer full is dropped and flagged.
//
// Ports:
//   CLK          in   system clock
//   RST          in   asynchronous active-low reset
//   ALU_OUT      in   [WIDTH-1:0]  ALU/compare result, valid with OUT_Valid
//   OUT_Valid    in   one-cycle qualifier per new result
//   TX_Busy      in   transmitter busy; rises after accepting a byte, falls at frame end
//   TX_P_DATA    out  [BYTE_W-1:0] byte presented to the transmitter
//   TX_D_VLD     out  one-cycle strobe qualifying TX_P_DATA
//   Sender_Busy  out  high whenever the sender is not idle
//   Overrun      out  one-cycle pulse when an incoming result is dropped
//   Result_Count out  [7:0] number of fully sent results, wrapping
module alu_result_sender #(
    parameter int WIDTH  = 16,
    parameter int BYTE_W = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [WIDTH-1:0]  ALU_OUT,
    input  logic              OUT_Valid,
    input  logic              TX_Busy,
    output logic [BYTE_W-1:0] TX_P_DATA,
    output logic              TX_D_VLD,
    output logic              Sender_Busy,
    output logic              Overrun,
    output logic [7:0]        Result_Count
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SEND_LO = 3'd1,
        ACK_LO  = 3'd2,
        DONE_LO = 3'd3,
        SEND_HI = 3'd4,
        ACK_HI  = 3'd5,
        DONE_HI = 3'd6
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  hold_q, hold_d;
    logic [WIDTH-1:0]  pend_q, pend_d;
    logic              pend_v_q, pend_v_d;
    logic [BYTE_W-1:0] tx_data_q, tx_data_d;
    logic              tx_vld_q, tx_vld_d;
    logic              overrun_q, overrun_d;
    logic [7:0]        count_q, count_d;

    // consumed: the incoming result was taken straight into HOLD this cycle.
    // pend_moving: PEND is being transferred to HOLD this cycle, so the
    // buffer is free to accept a new result at the same edge.
    logic              consumed;
    logic              pend_moving;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= IDLE;
            hold_q    <= '0;
            pend_q    <= '0;
            pend_v_q  <= 1'b0;
            tx_data_q <= '0;
            tx_vld_q  <= 1'b0;
            overrun_q <= 1'b0;
            count_q   <= 8'd0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            pend_q    <= pend_d;
            pend_v_q  <= pend_v_d;
            tx_data_q <= tx_data_d;
            tx_vld_q  <= tx_vld_d;
            overrun_q <= overrun_d;
            count_q   <= count_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        pend_d      = pend_q;
        pend_v_d    = pend_v_q;
        tx_data_d   = tx_data_q;
        tx_vld_d    = 1'b0;
        overrun_d   = 1'b0;
        count_d     = count_q;
        consumed    = 1'b0;
        pend_moving = 1'b0;

        case (state_q)
            IDLE: begin
                if (OUT_Valid) begin
                    hold_d   = ALU_OUT;
                    consumed = 1'b1;
                    state_d  = SEND_LO;
                end
            end
            SEND_LO: begin
                if (!TX_Busy) begin
                    tx_vld_d  = 1'b1;
                    tx_data_d = hold_q[BYTE_W-1:0];
                    state_d   = ACK_LO;
                end
            end
            ACK_LO: begin
                if (TX_Busy) begin
                    state_d = DONE_LO;
                end
            end
            DONE_LO: begin
                if (!TX_Busy) begin
                    state_d = SEND_HI;
                end
            end
            SEND_HI: begin
                if (!TX_Busy) begin
                    tx_vld_d  = 1'b1;
                    tx_data_d = hold_q[2*BYTE_W-1:BYTE_W];
                    state_d   = ACK_HI;
                end
            end
            ACK_HI: begin
                if (TX_Busy) begin
                    state_d = DONE_HI;
                end
            end
            DONE_HI: begin
                if (!TX_Busy) begin
                    count_d = count_q + 8'd1;
                    if (pend_v_q) begin
                        hold_d      = pend_q;
                        pend_v_d    = 1'b0;
                        pend_moving = 1'b1;
                        state_d     = SEND_LO;
                    end else if (OUT_Valid) begin
                        hold_d   = ALU_OUT;
                        consumed = 1'b1;
                        state_d  = SEND_LO;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A result not taken directly into HOLD goes to PEND if it is free
        // (or being vacated this very cycle); otherwise it is dropped.
        if (OUT_Valid && !consumed && (state_q != IDLE)) begin
            if (!pend_v_q || pend_moving) begin
                pend_d   = ALU_OUT;
                pend_v_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    assign TX_P_DATA    = tx_data_q;
    assign TX_D_VLD     = tx_vld_q;
    assign Sender_Busy  = (state_q != IDLE);
    assign Overrun      = overrun_q;
    assign Result_Count = count_q;

endmodule
